barrier_actuator_ctrl: RTL and testbench
========================================

# barrier_actuator_ctrl

Downstream stage of the crossing controller. Consumes the per-crossing `barrier_down` command vector and turns it into sequenced motor drive for each barrier arm. Per crossing, the sequence is: warning flash, then lowering, then confirmed closed, then raising. The block supervises two limit switches per arm with movement timeouts and latches a fault on any contradiction. It sits between `railway_controller_main` and the arm motor drivers, and its confirmed-closed/fault vectors feed back to supervision and statistics.

## Interface
Parameters:
- `NUM_CROSSINGS`, default 4: number of independent barrier channels.
- `WARN_CYCLES`, default 150_000_000: flash-only pre-warning before lowering (3 s at 50 MHz); minimum 1.
- `MOVE_TIMEOUT`, default 250_000_000: maximum cycles allowed for a lower or raise (5 s); minimum 1.
- `CNT_W`, default 32: width of each channel's timer.

Ports (N = `NUM_CROSSINGS`):
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `barrier_cmd` in N: 1 = close this crossing. Synchronous to `clk`; driven by the controller's `barrier_down`.
- `limit_up` in N: arm fully raised switch. Asynchronous input.
- `limit_down` in N: arm fully lowered switch. Asynchronous input.
- `fault_clear` in 1: single-cycle operator acknowledge, global to all channels.
- `motor_down` out N: drive arm down.
- `motor_up` out N: drive arm up.
- `flash_warn` out N: flash the warning lights.
- `barrier_closed` out N: arm confirmed down.
- `barrier_fault` out N: channel latched in FAULT.
- `state_out` out 3*N: channel i state at bits [3i+2:3i].

## Operation
- Each `limit_up`/`limit_down` bit passes through a 2-flop synchronizer. Below, `lu`/`ld` are the synchronized values.
- Each channel runs a Moore FSM with encodings UP=0, WARN=1, LOWERING=2, CLOSED=3, RAISING=4, FAULT=5. Codes 6 and 7 are illegal and go to FAULT.
- The timer clears on every state change and otherwise increments, saturating at all-ones.
- **UP:** if `cmd`, go to WARN.
- **WARN:** if `!cmd`, go to UP. Else if timer == `WARN_CYCLES`-1, go to LOWERING.
- **LOWERING:**
  - if `ld`, go to CLOSED;
  - else if `!cmd`, go to RAISING (reverse immediately);
  - else if timer == `MOVE_TIMEOUT`-1, go to FAULT.
- **CLOSED:** if `!ld`, go to FAULT (arm displaced); else if `!cmd`, go to RAISING.
- **RAISING:**
  - if `cmd`, go to LOWERING (no second warning; timer restarts);
  - else if `lu`, go to UP;
  - else if timer == `MOVE_TIMEOUT`-1, go to FAULT.
- **Any non-FAULT state:** `lu && ld` forces FAULT. This has top priority.
- **FAULT:** motors off. Exit only on `fault_clear` with `lu` XOR `ld`:
  - `ld && cmd`: go to CLOSED;
  - `lu`: go to UP;
  - any other combination: stay in FAULT.
- Output decode by state:
  - `motor_down` = LOWERING.
  - `motor_up` = RAISING.
  - `flash_warn` = WARN, LOWERING, CLOSED, RAISING or FAULT (lights fail-safe on).
  - `barrier_closed` = CLOSED.
  - `barrier_fault` = FAULT.
- Invariant: `motor_up & motor_down` == 0 for every channel, every cycle.
- Channels are fully independent. `fault_clear` acts on all faulted channels simultaneously.

## Timing
- **Reset:** all channels go to UP and timers clear. `motor_*`, `flash_warn`, `barrier_closed` and `barrier_fault` are 0; `state_out` is 0. Synchronizer flops reset to 0.
- Asserting `rst` mid-movement drops the motors asynchronously. After release, the FSM restarts from UP even if the arm is down: `cmd` high re-runs WARN, then LOWERING, and `ld` then closes it within 1 cycle of entering LOWERING.
- Outputs are combinational decode of the state register, so they change on the same edge as the state.
- `cmd` rising at edge k takes the channel to WARN at edge k+1. LOWERING is entered `WARN_CYCLES` cycles later.
- A limit switch edge reaches the FSM 2 cycles after the input changes. The state changes on the 3rd edge after the input edge.
- Timeout: FAULT is entered exactly `MOVE_TIMEOUT` cycles after entering LOWERING or RAISING.
- Simultaneous `!cmd` and `ld` in LOWERING: CLOSED wins, and RAISING follows on the next edge.

## Structure
- Package `railway_pkg` holds the 3-bit state typedef/constants and the default timing constants.
- Sub-module `barrier_channel_fsm`: one channel, containing the synchronizer, timer and FSM. The top instantiates it N times in a generate loop and concatenates the outputs.

## Test plan
Test parameters: `WARN_CYCLES`=4, `MOVE_TIMEOUT`=20.
1. **Normal close/open:** `cmd`[0]=1 → 4 cycles of `flash_warn`, then `motor_down`. Drive `ld` → `barrier_closed`[0]=1 three edges later. Drop `cmd` → `motor_up`. Drive `lu` → UP, all outputs 0.
2. **Close timeout:** `cmd`=1 with `ld` never asserted → `barrier_fault`=1 exactly 20 cycles after `motor_down` rose. `fault_clear` while `lu` high → UP.
3. **Reversal:** drop `cmd` mid-LOWERING → RAISING next edge. Re-raise `cmd` mid-RAISING → LOWERING, with no `motor_up`/`motor_down` overlap at any cycle.
4. **Displacement:** in CLOSED, release `ld` → FAULT 3 edges later with `flash_warn` held at 1. `fault_clear` with both switches low → stays in FAULT.
5. **Contradiction and isolation:** `lu`=`ld`=1 on channel 2 → only `barrier_fault`[2] sets. Channels 0, 1 and 3 continue their sequences unaffected.
6. **Reset:** assert `rst` during LOWERING → `motor_down` is 0 immediately and `state_out`=0. After release with `cmd` still high → WARN on the next edge.

Source files
------------

// File: rtl/railway_pkg.sv
// rtl/railway_pkg.sv - barrier channel state encoding and default timing constants
package railway_pkg;

  localparam int STATE_W              = 3;
  localparam int DEFAULT_WARN_CYCLES  = 150_000_000;
  localparam int DEFAULT_MOVE_TIMEOUT = 250_000_000;
  localparam int DEFAULT_CNT_W        = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_UP       = 3'd0,
    ST_WARN     = 3'd1,
    ST_LOWERING = 3'd2,
    ST_CLOSED   = 3'd3,
    ST_RAISING  = 3'd4,
    ST_FAULT    = 3'd5
  } barrier_state_e;

  // Both limit switches closed at once cannot happen on a healthy arm.
  function automatic logic switches_contradict(input logic lu, input logic ld);
    return lu & ld;
  endfunction

endpackage

// File: rtl/barrier_actuator_ctrl_if.sv
// rtl/barrier_actuator_ctrl_if.sv - command, limit-switch and motor/status bundle for the barrier block
interface barrier_actuator_ctrl_if #(
  parameter int NUM_CROSSINGS = 4
);

  logic [NUM_CROSSINGS-1:0]   barrier_cmd;
  logic [NUM_CROSSINGS-1:0]   limit_up;
  logic [NUM_CROSSINGS-1:0]   limit_down;
  logic                       fault_clear;
  logic [NUM_CROSSINGS-1:0]   motor_down;
  logic [NUM_CROSSINGS-1:0]   motor_up;
  logic [NUM_CROSSINGS-1:0]   flash_warn;
  logic [NUM_CROSSINGS-1:0]   barrier_closed;
  logic [NUM_CROSSINGS-1:0]   barrier_fault;
  logic [3*NUM_CROSSINGS-1:0] state_out;

  modport master (
    output barrier_cmd, limit_up, limit_down, fault_clear,
    input  motor_down, motor_up, flash_warn, barrier_closed, barrier_fault, state_out
  );

  modport slave (
    input  barrier_cmd, limit_up, limit_down, fault_clear,
    output motor_down, motor_up, flash_warn, barrier_closed, barrier_fault, state_out
  );

endinterface

// File: rtl/barrier_channel_fsm.sv
// rtl/barrier_channel_fsm.sv - one barrier arm: limit-switch synchronizers, movement timer and sequencing FSM
module barrier_channel_fsm
  import railway_pkg::*;
#(
  parameter int WARN_CYCLES  = DEFAULT_WARN_CYCLES,
  parameter int MOVE_TIMEOUT = DEFAULT_MOVE_TIMEOUT,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_i,
  input  logic               limit_up_i,
  input  logic               limit_down_i,
  input  logic               fault_clear_i,
  output logic               motor_down_o,
  output logic               motor_up_o,
  output logic               flash_warn_o,
  output logic               closed_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);

  logic [1:0]       lu_sync_q;
  logic [1:0]       ld_sync_q;
  logic             lu;
  logic             ld;
  barrier_state_e   state_q;
  barrier_state_e   state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;

  assign lu = lu_sync_q[1];
  assign ld = ld_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_sync_q <= 2'b00;
      ld_sync_q <= 2'b00;
      state_q   <= ST_UP;
      timer_q   <= '0;
    end else begin
      lu_sync_q <= {lu_sync_q[0], limit_up_i};
      ld_sync_q <= {ld_sync_q[0], limit_down_i};
      state_q   <= state_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_FAULT && switches_contradict(lu, ld)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_UP:       if (cmd_i) state_d = ST_WARN;
        ST_WARN:     if (!cmd_i) state_d = ST_UP;
                     else if (timer_q == WARN_LAST) state_d = ST_LOWERING;
        ST_LOWERING: if (ld) state_d = ST_CLOSED;
                     else if (!cmd_i) state_d = ST_RAISING;
                     else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
        ST_CLOSED:   if (!ld) state_d = ST_FAULT;
                     else if (!cmd_i) state_d = ST_RAISING;
        // A reversal skips the warning: lights are already flashing.
        ST_RAISING:  if (cmd_i) state_d = ST_LOWERING;
                     else if (lu) state_d = ST_UP;
                     else if (timer_q == MOVE_LAST) state_d = ST_FAULT;
        ST_FAULT:    if (fault_clear_i && (lu ^ ld)) begin
                       if (ld && cmd_i) state_d = ST_CLOSED;
                       else if (lu) state_d = ST_UP;
                     end
        default:     state_d = ST_FAULT;
      endcase
    end
    if (state_d != state_q) timer_d = '0;
    else if (&timer_q)      timer_d = timer_q;
    else                    timer_d = timer_q + CNT_W'(1);
  end

  // Lights stay on in every state but UP, including FAULT and illegal codes.
  always_comb begin
    motor_down_o = 1'b0;
    motor_up_o   = 1'b0;
    flash_warn_o = 1'b1;
    closed_o     = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      ST_UP:       flash_warn_o = 1'b0;
      ST_LOWERING: motor_down_o = 1'b1;
      ST_CLOSED:   closed_o     = 1'b1;
      ST_RAISING:  motor_up_o   = 1'b1;
      ST_FAULT:    fault_o      = 1'b1;
      default:     ;
    endcase
    state_o = state_q;
  end

endmodule

// File: rtl/barrier_actuator_ctrl.sv
// rtl/barrier_actuator_ctrl.sv - N independent barrier arm sequencers behind one interface
module barrier_actuator_ctrl
  import railway_pkg::*;
#(
  parameter int NUM_CROSSINGS = 4,
  parameter int WARN_CYCLES   = DEFAULT_WARN_CYCLES,
  parameter int MOVE_TIMEOUT  = DEFAULT_MOVE_TIMEOUT,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  barrier_actuator_ctrl_if.slave ctrl
);

  logic [NUM_CROSSINGS-1:0]         motor_down_w;
  logic [NUM_CROSSINGS-1:0]         motor_up_w;
  logic [NUM_CROSSINGS-1:0]         flash_warn_w;
  logic [NUM_CROSSINGS-1:0]         closed_w;
  logic [NUM_CROSSINGS-1:0]         fault_w;
  logic [STATE_W*NUM_CROSSINGS-1:0] state_w;

  for (genvar gi = 0; gi < NUM_CROSSINGS; gi++) begin : g_ch
    barrier_channel_fsm #(
      .WARN_CYCLES  (WARN_CYCLES),
      .MOVE_TIMEOUT (MOVE_TIMEOUT),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .cmd_i         (ctrl.barrier_cmd[gi]),
      .limit_up_i    (ctrl.limit_up[gi]),
      .limit_down_i  (ctrl.limit_down[gi]),
      .fault_clear_i (ctrl.fault_clear),
      .motor_down_o  (motor_down_w[gi]),
      .motor_up_o    (motor_up_w[gi]),
      .flash_warn_o  (flash_warn_w[gi]),
      .closed_o      (closed_w[gi]),
      .fault_o       (fault_w[gi]),
      .state_o       (state_w[STATE_W*gi +: STATE_W])
    );
  end

  assign ctrl.motor_down     = motor_down_w;
  assign ctrl.motor_up       = motor_up_w;
  assign ctrl.flash_warn     = flash_warn_w;
  assign ctrl.barrier_closed = closed_w;
  assign ctrl.barrier_fault  = fault_w;
  assign ctrl.state_out      = state_w;

endmodule

// File: tb/tb_barrier_actuator_ctrl.sv
// tb/tb_barrier_actuator_ctrl.sv - directed and randomized checks of barrier_actuator_ctrl against a cycle model
module tb_barrier_actuator_ctrl;

  localparam int N = 4;
  localparam int W = 4;
  localparam int M = 20;

  localparam int S_UP = 0, S_WARN = 1, S_LOW = 2, S_CLOSED = 3, S_RAISE = 4, S_FAULT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cmd = '0;
  logic [N-1:0] lu  = '1;
  logic [N-1:0] ld  = '0;
  logic         clr = 1'b0;

  int tests = 0;
  int fails = 0;

  int m_st  [N];
  int m_age [N];
  bit su1 [N], su2 [N], sd1 [N], sd2 [N];
  int pos   [N];
  bit stuck [N];
  int n;

  always #5 clk = ~clk;

  barrier_actuator_ctrl_if #(.NUM_CROSSINGS(N)) bus ();

  assign bus.barrier_cmd = cmd;
  assign bus.limit_up    = lu;
  assign bus.limit_down  = ld;
  assign bus.fault_clear = clr;

  barrier_actuator_ctrl #(
    .NUM_CROSSINGS (N),
    .WARN_CYCLES   (W),
    .MOVE_TIMEOUT  (M),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaviour of one arm written as the plain rule list, highest priority first.
  function automatic int next_st(input int st, input int age, input bit c,
                                 input bit u, input bit d, input bit fc);
    if (st != S_FAULT && u && d) return S_FAULT;
    case (st)
      S_UP:     return c ? S_WARN : S_UP;
      S_WARN:   begin
                  if (!c) return S_UP;
                  return (age == W - 1) ? S_LOW : S_WARN;
                end
      S_LOW:    begin
                  if (d)  return S_CLOSED;
                  if (!c) return S_RAISE;
                  return (age == M - 1) ? S_FAULT : S_LOW;
                end
      S_CLOSED: begin
                  if (!d) return S_FAULT;
                  return c ? S_CLOSED : S_RAISE;
                end
      S_RAISE:  begin
                  if (c) return S_LOW;
                  if (u) return S_UP;
                  return (age == M - 1) ? S_FAULT : S_RAISE;
                end
      default:  begin
                  if (fc && (u != d)) begin
                    if (d && c) return S_CLOSED;
                    if (u)      return S_UP;
                  end
                  return S_FAULT;
                end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = S_UP; m_age[i] = 0;
      su1[i] = 0; su2[i] = 0; sd1[i] = 0; sd2[i] = 0;
    end
  endtask

  task automatic model_step();
    int nx;
    for (int i = 0; i < N; i++) begin
      nx = next_st(m_st[i], m_age[i], cmd[i], su2[i], sd2[i], clr);
      m_age[i] = (nx == m_st[i]) ? m_age[i] + 1 : 0;
      m_st[i]  = nx;
      su2[i] = su1[i]; su1[i] = lu[i];
      sd2[i] = sd1[i]; sd1[i] = ld[i];
    end
  endtask

  task automatic check_all();
    logic [3*N-1:0] e_st;
    logic [N-1:0]   e_md, e_mu, e_fw, e_bc, e_bf;
    for (int i = 0; i < N; i++) begin
      e_st[3*i +: 3] = 3'(m_st[i]);
      e_md[i] = (m_st[i] == S_LOW);
      e_mu[i] = (m_st[i] == S_RAISE);
      e_fw[i] = (m_st[i] != S_UP);
      e_bc[i] = (m_st[i] == S_CLOSED);
      e_bf[i] = (m_st[i] == S_FAULT);
    end
    chk("state_out", 32'(bus.state_out), 32'(e_st));
    chk("outputs", 32'({bus.motor_down, bus.motor_up, bus.flash_warn, bus.barrier_closed, bus.barrier_fault}),
        32'({e_md, e_mu, e_fw, e_bc, e_bf}));
    chk("interlock", 32'(bus.motor_down & bus.motor_up), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all();
  endtask

  task automatic wait_state(input int ch, input int code, input int max, output int cnt);
    cnt = 0;
    while (cnt < max && int'(bus.state_out[3*ch +: 3]) != code) begin
      tick();
      cnt++;
    end
  endtask

  task automatic park_all_up();
    cmd = '0; lu = '1; ld = '0;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    chk("reset_state", 32'(bus.state_out), 32'd0);
    chk("reset_outs", 32'({bus.motor_down, bus.motor_up, bus.flash_warn, bus.barrier_closed, bus.barrier_fault}), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Normal close and open on channel 0
    cmd[0] = 1'b1; tick();
    chk("s1_warn_entry", 32'(bus.state_out[2:0]), 32'(S_WARN));
    wait_state(0, S_LOW, 50, n);
    chk("s1_warn_len", 32'(n), 32'(W));
    lu[0] = 1'b0; tick();
    ld[0] = 1'b1;
    wait_state(0, S_CLOSED, 50, n);
    chk("s1_close_lat", 32'(n), 32'd3);
    chk("s1_closed", 32'(bus.barrier_closed[0]), 32'd1);
    cmd[0] = 1'b0; tick();
    chk("s1_motor_up", 32'(bus.motor_up[0]), 32'd1);
    ld[0] = 1'b0; lu[0] = 1'b1;
    wait_state(0, S_UP, 50, n);
    chk("s1_up_lat", 32'(n), 32'd3);

    // Close timeout on channel 1
    cmd[1] = 1'b1;
    wait_state(1, S_LOW, 50, n);
    lu[1] = 1'b0;
    wait_state(1, S_FAULT, 60, n);
    chk("s2_timeout", 32'(n), 32'(M));
    cmd[1] = 1'b0; lu[1] = 1'b1;
    repeat (2) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("s2_recover", 32'(bus.state_out[5:3]), 32'(S_UP));

    // Reversal on channel 0
    cmd[0] = 1'b1;
    wait_state(0, S_LOW, 50, n);
    lu[0] = 1'b0;
    repeat (3) tick();
    cmd[0] = 1'b0; tick();
    chk("s3_reverse_up", 32'(bus.state_out[2:0]), 32'(S_RAISE));
    repeat (2) tick();
    cmd[0] = 1'b1; tick();
    chk("s3_reverse_down", 32'(bus.state_out[2:0]), 32'(S_LOW));
    cmd[0] = 1'b0; tick();
    lu[0] = 1'b1;
    wait_state(0, S_UP, 50, n);

    // Displacement on channel 3
    cmd[3] = 1'b1;
    wait_state(3, S_LOW, 50, n);
    lu[3] = 1'b0; ld[3] = 1'b1;
    wait_state(3, S_CLOSED, 50, n);
    ld[3] = 1'b0;
    wait_state(3, S_FAULT, 50, n);
    chk("s4_displace_lat", 32'(n), 32'd3);
    chk("s4_flash_held", 32'(bus.flash_warn[3]), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("s4_clear_no_switch", 32'(bus.state_out[11:9]), 32'(S_FAULT));
    cmd[3] = 1'b0; lu[3] = 1'b1;
    repeat (2) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("s4_recover", 32'(bus.state_out[11:9]), 32'(S_UP));

    // Contradiction on channel 2 while 0 and 1 sequence
    cmd[0] = 1'b1; cmd[1] = 1'b1;
    lu[2] = 1'b1; ld[2] = 1'b1;
    repeat (3) tick();
    chk("s5_fault_only_2", 32'(bus.barrier_fault), 32'b0100);
    wait_state(0, S_LOW, 50, n);
    chk("s5_ch0_lowering", 32'(bus.motor_down[1:0]), 32'b11);
    ld[2] = 1'b0;
    repeat (2) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("s5_ch2_recover", 32'(bus.state_out[8:6]), 32'(S_UP));
    park_all_up();

    // Reset during LOWERING
    cmd[0] = 1'b1;
    wait_state(0, S_LOW, 50, n);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("s6_motor_drop", 32'(bus.motor_down[0]), 32'd0);
    chk("s6_state_clear", 32'(bus.state_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("s6_warn_after_rst", 32'(bus.state_out[2:0]), 32'(S_WARN));
    park_all_up();

    // Randomized operation with a simple arm plant
    for (int i = 0; i < N; i++) begin pos[i] = 0; stuck[i] = 0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) cmd[i] = ~cmd[i];
        if ($urandom_range(0, 99) == 0) stuck[i] = ~stuck[i];
        if (!stuck[i] && $urandom_range(0, 3) != 0) begin
          if (m_st[i] == S_LOW && pos[i] < 6)        pos[i]++;
          else if (m_st[i] == S_RAISE && pos[i] > 0) pos[i]--;
        end
        if (m_st[i] == S_CLOSED && $urandom_range(0, 299) == 0) pos[i] = 5;
        if (m_st[i] == S_FAULT && $urandom_range(0, 29) == 0) pos[i] = ($urandom_range(0, 1) == 0) ? 0 : 6;
        lu[i] = (pos[i] == 0);
        ld[i] = (pos[i] == 6);
        if ($urandom_range(0, 249) == 0) begin lu[i] = 1'b1; ld[i] = 1'b1; end
      end
      clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
